// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags; dout registered, 1-cycle read latency.
// Back-pressure via full/almost_full (writes dropped when full); define FIFO_FWFT_EN for the show-ahead output register.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH       = 16,
  parameter int FIFO_DEPTH       = 512,
  parameter int ALMOST_FULL_LVL  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FIFO_WIDTH-1:0]       din,
  input  logic                        wen,
  input  logic                        ren,
  input  logic                        clr_err,
  output logic [FIFO_WIDTH-1:0]       dout,
  output logic                        valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LVL);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  w_acc;
  logic                  r_acc;
  logic                  load;
  logic                  unf_set;
  logic                  valid_nxt;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign w_acc = wen && !full;

`ifdef FIFO_FWFT_EN
  // count includes the word parked in dout, so memory holds count - valid
  logic [CW-1:0] mem_cnt;
  assign mem_cnt   = count - CW'(valid);
  assign r_acc     = ren && valid;
  assign load      = (mem_cnt != '0) && (!valid || r_acc);
  assign unf_set   = ren && !valid;
  assign valid_nxt = load || (valid && !r_acc);
`else
  assign r_acc     = ren && !empty;
  assign load      = r_acc;
  assign unf_set   = ren && empty;
  assign valid_nxt = r_acc;
`endif

  always_ff @(posedge clk) begin
    if (w_acc) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_acc) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      valid     <= valid_nxt;
      count     <= count + CW'(w_acc) - CW'(r_acc);
      // a new error in the same cycle as clr_err wins
      overflow  <= (wen && full) || (overflow && !clr_err);
      underflow <= unf_set || (underflow && !clr_err);
    end
  end

endmodule
